// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : otter_pkg
// Purpose  : Shared opcode encoding, register-usage decode helpers and
//            forwarding-select constants for the operand forwarding logic.
// Revision : 1.0 - initial release
// ============================================================================
package otter_pkg;

    // RV32I major opcodes seen at the issue stage
    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP_RG3 = 7'b0110011,
        OPC_CSR    = 7'b1110011
    } opcode_t;

    // Select value 0 always means "read the register file"; k>0 means stage k
    localparam int C_SEL_RF = 0;

    // Instruction reads rs1
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_CSR,
            OPC_BRANCH, OPC_OP_RG3, OPC_STORE: uses_rs1 = 1'b1;
            default:                           uses_rs1 = 1'b0;
        endcase
    endfunction

    // Instruction reads rs2
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OPC_BRANCH, OPC_OP_RG3, OPC_STORE: uses_rs2 = 1'b1;
            default:                           uses_rs2 = 1'b0;
        endcase
    endfunction

    // Instruction writes rd; stores, branches and unknown opcodes never do
    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OP_IMM, OPC_OP_RG3, OPC_CSR: writes_rd = 1'b1;
            default:                                  writes_rd = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_src_match.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_match
// Purpose  : Priority match of one source register against the scoreboard.
//            Youngest valid matching entry wins; a load that is still in a
//            non-forwardable stage raises a hazard instead of a select.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_src_match
    import otter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int SW       = 2
)(
    input  logic                  i_used,
    input  logic [4:0]            i_addr,
    input  logic [DEPTH-1:0]      i_ent_valid,
    input  logic [DEPTH-1:0][4:0] i_ent_rd,
    input  logic [DEPTH-1:0]      i_ent_load,
    output logic [SW-1:0]         o_sel,
    output logic                  o_hazard
);

    logic w_found;

    // Scan from youngest (stage 1) to oldest; the first hit masks older ones
    always_comb begin
        o_sel    = SW'(C_SEL_RF);
        o_hazard = 1'b0;
        w_found  = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!w_found && i_used && (i_addr != 5'd0) &&
                i_ent_valid[k-1] && (i_ent_rd[k-1] == i_addr)) begin
                w_found = 1'b1;
                if (i_ent_load[k-1] && (k <= LOAD_LAT)) begin
                    o_hazard = 1'b1;
                end else begin
                    o_sel = SW'(k);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_scoreboard
// Purpose  : Destination-register scoreboard for post-EX stages producing
//            zero-latency forwarding selects, load-use stall and a
//            saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
    import otter_pkg::*;
#(
    parameter  int DEPTH    = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 16,
    localparam int SW       = $clog2(DEPTH + 1)
)(
    input  logic             CLK,
    input  logic             RST,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    output logic [SW-1:0]    fwd_a,
    output logic [SW-1:0]    fwd_b,
    output logic [SW-1:0]    fwd_store,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    // Index 0 holds stage 1 (EX/MEM), index DEPTH-1 the oldest tracked stage
    logic [DEPTH-1:0]      r_ent_valid;
    logic [DEPTH-1:0][4:0] r_ent_rd;
    logic [DEPTH-1:0]      r_ent_load;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic [SW-1:0] w_sel_a;
    logic [SW-1:0] w_sel_b;
    logic          w_haz_a;
    logic          w_haz_b;
    logic          w_stall;
    logic          w_gate;
    logic          w_is_store;
    logic          w_enter;

    fwd_src_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_rs1 (
        .i_used      (uses_rs1(id_opcode)),
        .i_addr      (id_rs1),
        .i_ent_valid (r_ent_valid),
        .i_ent_rd    (r_ent_rd),
        .i_ent_load  (r_ent_load),
        .o_sel       (w_sel_a),
        .o_hazard    (w_haz_a)
    );

    fwd_src_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_rs2 (
        .i_used      (uses_rs2(id_opcode)),
        .i_addr      (id_rs2),
        .i_ent_valid (r_ent_valid),
        .i_ent_rd    (r_ent_rd),
        .i_ent_load  (r_ent_load),
        .o_sel       (w_sel_b),
        .o_hazard    (w_haz_b)
    );

    // Flush kills the instruction, so it can never stall
    assign w_stall    = id_valid & ~flush & (w_haz_a | w_haz_b);
    assign w_gate     = id_valid & ~w_stall;
    assign w_is_store = (id_opcode == OPC_STORE);
    assign w_enter    = id_valid & ~flush & ~w_stall & writes_rd(id_opcode) & (id_rd != 5'd0);

    // Selects are forced to the register file while stalled or idle
    always_comb begin
        fwd_a     = w_gate ? w_sel_a : SW'(C_SEL_RF);
        fwd_b     = SW'(C_SEL_RF);
        fwd_store = SW'(C_SEL_RF);
        if (w_gate) begin
            if (w_is_store) fwd_store = w_sel_b;
            else            fwd_b     = w_sel_b;
        end
    end

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

    // Advance the scoreboard one stage per unfrozen cycle and count stalls
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ent_valid <= '0;
            r_ent_rd    <= '0;
            r_ent_load  <= '0;
            r_stall_cnt <= '0;
        end else if (!freeze) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_ent_valid[k] <= r_ent_valid[k-1];
                r_ent_rd[k]    <= r_ent_rd[k-1];
                r_ent_load[k]  <= r_ent_load[k-1];
            end
            r_ent_valid[0] <= w_enter;
            r_ent_rd[0]    <= w_enter ? id_rd : 5'd0;
            r_ent_load[0]  <= w_enter & (id_opcode == OPC_LOAD);
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_scoreboard
// Purpose  : Directed self-checking bench for fwd_scoreboard (DEPTH=2 and
//            DEPTH=4/LOAD_LAT=2 instances driven from shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;
    import otter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [6:0]  id_opcode = 7'd0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic [4:0]  id_rd = 5'd0;

    logic [1:0]  fwd_a, fwd_b, fwd_store;
    logic        stall;
    logic [15:0] stall_cnt;

    logic [2:0]  fwd_a4, fwd_b4, fwd_store4;
    logic        stall4;
    logic [15:0] stall_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fwd_scoreboard u_dut (
        .CLK(CLK), .RST(RST), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_store(fwd_store),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_scoreboard #(.DEPTH(4), .LOAD_LAT(2), .CNT_W(16)) u_dut4 (
        .CLK(CLK), .RST(RST), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .fwd_store(fwd_store4),
        .stall(stall4), .stall_cnt(stall_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one issue-stage instruction just after a falling edge
    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic fl, input logic fz);
        @(negedge CLK);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
        flush     = fl;
        freeze    = fz;
        #1;
    endtask

    task automatic do_reset(input logic fz);
        @(negedge CLK);
        RST = 1'b1; id_valid = 1'b0; flush = 1'b0; freeze = fz;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0; freeze = 1'b0;
    endtask

    initial begin
        do_reset(1'b0);

        // Reset state with a would-be consumer present
        drive(1, OPC_OP_RG3, 5'd1, 5'd2, 5'd5, 0, 0);              // ADD x5,x1,x2
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt",   stall_cnt, 0);

        // Back-to-back ALU dependency
        drive(1, OPC_OP_RG3, 5'd5, 5'd5, 5'd6, 0, 0);              // ADD x6,x5,x5
        chk("alu_fwd_a", fwd_a, 1);
        chk("alu_fwd_b", fwd_b, 1);
        chk("alu_stall", stall, 0);

        // One NOP between producer and consumer
        drive(1, OPC_OP_RG3, 5'd1, 5'd2, 5'd5, 0, 0);              // ADD x5
        drive(1, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 0, 0);              // NOP
        drive(1, OPC_OP_RG3, 5'd5, 5'd5, 5'd6, 0, 0);              // ADD x6,x5,x5
        chk("nop_fwd_a", fwd_a, 2);
        chk("nop_fwd_b", fwd_b, 2);

        // Load-use into a store
        drive(1, OPC_LOAD, 5'd1, 5'd0, 5'd7, 0, 0);                // LW x7,0(x1)
        drive(1, OPC_STORE, 5'd7, 5'd7, 5'd0, 0, 0);               // SW x7,0(x7)
        chk("lu_stall", stall, 1);
        chk("lu_sel_a", fwd_a, 0);
        drive(1, OPC_STORE, 5'd7, 5'd7, 5'd0, 0, 0);               // retry
        chk("lu_stall2", stall, 0);
        chk("lu_cnt",    stall_cnt, 1);
        chk("lu_fwd_a",  fwd_a, 2);
        chk("lu_fwd_st", fwd_store, 2);
        chk("lu_fwd_b",  fwd_b, 0);

        // Youngest of two matching producers wins
        drive(1, OPC_OP_IMM, 5'd1, 5'd0, 5'd3, 0, 0);              // ADDI x3,x1,1
        drive(1, OPC_OP_IMM, 5'd3, 5'd0, 5'd3, 0, 0);              // ADDI x3,x3,1
        chk("yng_chain", fwd_a, 1);
        drive(1, OPC_OP_RG3, 5'd3, 5'd0, 5'd4, 0, 0);              // ADD x4,x3,x0
        chk("yng_fwd_a", fwd_a, 1);
        chk("yng_fwd_b", fwd_b, 0);

        // Load-use with freeze held for three cycles
        drive(1, OPC_LOAD, 5'd0, 5'd0, 5'd2, 0, 0);                // LW x2,0(x0)
        for (int i = 0; i < 3; i++) begin
            drive(1, OPC_OP_RG3, 5'd2, 5'd0, 5'd10, 0, 1);         // ADD x10,x2,x0 frozen
            chk("frz_stall", stall, 1);
            chk("frz_cnt",   stall_cnt, 1);
        end
        drive(1, OPC_OP_RG3, 5'd2, 5'd0, 5'd10, 0, 0);
        chk("frz_rel_stall", stall, 1);
        chk("frz_rel_cnt",   stall_cnt, 1);
        drive(1, OPC_OP_RG3, 5'd2, 5'd0, 5'd10, 0, 0);
        chk("frz_fwd_stall", stall, 0);
        chk("frz_fwd_a",     fwd_a, 2);
        chk("frz_fwd_cnt",   stall_cnt, 2);

        // Flushed writer enters as a bubble
        drive(1, OPC_OP_RG3, 5'd1, 5'd1, 5'd8, 1, 0);              // ADD x8 flushed
        drive(1, OPC_OP_RG3, 5'd8, 5'd0, 5'd1, 0, 0);              // ADD x1,x8,x0
        chk("fl_fwd_a", fwd_a, 0);

        // Flush outranks a load-use stall; the load still forwards later
        drive(1, OPC_LOAD, 5'd0, 5'd0, 5'd11, 0, 0);               // LW x11
        drive(1, OPC_OP_RG3, 5'd11, 5'd0, 5'd12, 1, 0);            // flushed consumer
        chk("flpri_stall", stall, 0);
        drive(1, OPC_OP_RG3, 5'd11, 5'd0, 5'd13, 0, 0);
        chk("flpri_stall2", stall, 0);
        chk("flpri_fwd_a",  fwd_a, 2);

        // Writes to x0 are never tracked
        drive(1, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 0, 0);              // ADDI x0,x1,5
        drive(1, OPC_OP_RG3, 5'd0, 5'd0, 5'd14, 0, 0);             // ADD x14,x0,x0
        chk("x0_fwd_a", fwd_a, 0);
        chk("x0_fwd_b", fwd_b, 0);

        // Reset mid-sequence, asserted together with freeze
        drive(1, OPC_OP_RG3, 5'd1, 5'd1, 5'd15, 0, 0);             // ADD x15
        do_reset(1'b1);
        drive(1, OPC_OP_RG3, 5'd15, 5'd15, 5'd16, 0, 0);
        chk("mrst_fwd_a", fwd_a, 0);
        chk("mrst_fwd_b", fwd_b, 0);
        chk("mrst_cnt",   stall_cnt, 0);

        // DEPTH=4, LOAD_LAT=2: two-cycle load-use stall then stage-3 forward
        do_reset(1'b0);
        drive(1, OPC_LOAD, 5'd0, 5'd0, 5'd9, 0, 0);                // LW x9
        drive(1, OPC_OP_RG3, 5'd9, 5'd9, 5'd1, 0, 0);              // OR x1,x9,x9
        chk("d4_stall1", stall4, 1);
        drive(1, OPC_OP_RG3, 5'd9, 5'd9, 5'd1, 0, 0);
        chk("d4_stall2", stall4, 1);
        chk("d4_cnt1",   stall_cnt4, 1);
        drive(1, OPC_OP_RG3, 5'd9, 5'd9, 5'd1, 0, 0);
        chk("d4_stall3", stall4, 0);
        chk("d4_fwd_a",  fwd_a4, 3);
        chk("d4_fwd_b",  fwd_b4, 3);
        chk("d4_cnt2",   stall_cnt4, 2);

        drive(0, OPC_OP_IMM, 5'd0, 5'd0, 5'd0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the number of post-EX stages tracked (1..6); stage 1 = EX/MEM, stage 2 = MEM/WB, and so on.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, meaning the last stage in which load data is not yet forwardable (0 <= LOAD_LAT < DEPTH).
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the width of the stall counter.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Ports SHALL be:
  CLK  in  1  rising-edge clock
  RST  in  1  synchronous active-high reset
  freeze  in  1  pipeline hold (cache miss); scoreboard holds
  flush  in  1  issuing instruction is killed (taken branch/jump)
  id_valid  in  1  issuing instruction valid
  id_opcode  in  7  issuing opcode
  id_rs1, id_rs2, id_rd  in  5 each  issuing register addresses
  fwd_a  out  SW  rs1 source select
  fwd_b  out  SW  rs2 source select (non-store)
  fwd_store  out  SW  store-data source select
  stall  out  1  hold issuing instruction, inject bubble
  stall_cnt  out  CNT_W  saturating count of stall cycles
  where SW = $clog2(DEPTH+1).

Function
REQ-006 Select encoding SHALL be: 0 = register file; k = result in stage k, for 1..DEPTH.
REQ-007 Scoreboard entries 1..DEPTH SHALL each hold {valid, rd[4:0], is_load}.
REQ-008 rs1 SHALL be used by JALR, LOAD, OP_IMM, CSR, BRANCH, OP_RG3, STORE; rs2 SHALL be used by BRANCH, OP_RG3, STORE.
REQ-009 Writers SHALL be LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP_RG3, CSR; STORE, BRANCH and unknown opcodes SHALL never create valid entries.
REQ-010 Per used source, the block SHALL take the youngest (lowest k) valid entry whose rd equals the source address and is nonzero; older matches SHALL be ignored.
REQ-011 If that youngest match has is_load=1 and k <= LOAD_LAT, the hazard SHALL be set; otherwise the select SHALL be k.
REQ-012 Unused sources and x0 SHALL select 0.
REQ-013 The rs2 select SHALL drive fwd_store when the opcode is STORE (fwd_b = 0), and SHALL drive fwd_b otherwise (fwd_store = 0).
REQ-014 stall SHALL equal id_valid & !flush & (hazard on any used source); all selects SHALL be 0 whenever stall=1 or id_valid=0.
REQ-015 Selects and stall SHALL be combinational from current inputs and registered scoreboard (zero latency).
REQ-016 On an edge with freeze=0, entry[k+1] SHALL take entry[k] for k = 1..DEPTH-1, and entry[DEPTH] SHALL be discarded.
REQ-017 On the same edge, entry[1] SHALL take {1, id_rd, opcode==LOAD} when id_valid & !flush & !stall & writer & id_rd != 0, and SHALL be invalid (bubble) otherwise.
REQ-018 On an edge with freeze=1, all entries and stall_cnt SHALL hold; outputs SHALL remain combinationally valid.
REQ-019 flush SHALL take priority over stall (stall=0), and the flushed instruction SHALL enter as a bubble.
REQ-020 stall_cnt SHALL increment on every edge with stall=1 & freeze=0 and SHALL saturate at all-ones.
REQ-021 With DEPTH=2 and LOAD_LAT=1, behaviour SHALL match classic EX/MEM + MEM/WB forwarding with a one-cycle load-use stall.

Reset
REQ-022 On an edge with RST=1, all entries SHALL be cleared to invalid and stall_cnt SHALL be cleared to 0; RST SHALL override freeze.
REQ-023 During reset, combinational outputs SHALL reflect the current state; after the reset edge, all selects and stall SHALL be 0 for any input.

Structure
REQ-024 opcode_t, uses_rs1/uses_rs2/writes_rd functions and the select-encoding constants SHALL live in shared package otter_pkg.
REQ-025 One sub-module, fwd_src_match (priority match for one source over the scoreboard → select + hazard), SHALL be instantiated twice (rs1, rs2).

Verification
REQ-026 The bench SHALL cover: ADD x5 then ADD x6,x5,x5 → fwd_a=1, fwd_b=1, stall=0; with one NOP between → both =2.
REQ-027 The bench SHALL cover: LW x7 then SW x7,0(x7) → stall=1 for 1 cycle, stall_cnt=1; next cycle fwd_a=2, fwd_store=2, fwd_b=0.
REQ-028 The bench SHALL cover: ADDI x3 twice back-to-back, then ADD x4,x3,x0 → fwd_a=1 (youngest wins), fwd_b=0.
REQ-029 The bench SHALL cover: DEPTH=4, LOAD_LAT=2 with LW x9 then OR x1,x9,x9 → 2 stall cycles, then fwd_a=fwd_b=3.
REQ-030 The bench SHALL cover: LW x2 followed by consumer with freeze=1 for 3 cycles → stall held high, stall_cnt unchanged; after release → one counted stall, then forward from stage 2.
REQ-031 The bench SHALL cover: ADD x8 with flush=1, then ADD x1,x8,x0 → fwd_a=0; writer to x0 then consumer of x0 → selects 0; RST mid-sequence → all entries invalid, stall_cnt=0.
